// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared types and constants for the core memory arbiter
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam logic [3:0] FETCH_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - fetch, data and downstream Avalon-MM signal group
interface core_mem_arbiter_if;

  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_readdata;
  logic        i_waitrequest;

  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;

  logic [31:0] m_addr;
  logic [31:0] m_writedata;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  // Arbiter side: serves the core ports and masters the interconnect.
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_writedata, d_byteenable,
    input  m_readdata, m_waitrequest,
    output i_readdata, i_waitrequest, d_readdata, d_waitrequest,
    output m_addr, m_writedata, m_read, m_write, m_byteenable
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_writedata, d_byteenable,
    output m_readdata, m_waitrequest,
    input  i_readdata, i_waitrequest, d_readdata, d_waitrequest,
    input  m_addr, m_writedata, m_read, m_write, m_byteenable
  );

endinterface

// File: rtl/core_mem_arb_select.sv
// rtl/core_mem_arb_select.sv - combinational grant decision with data streak limit
module core_mem_arb_select
  import core_mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic [3:0] data_streak,
  input  logic       arb_hold,
  output logic       grant_valid,
  output arb_port_t  grant_port
);

  always_comb begin
    grant_valid = !arb_hold && (i_req || d_req);
    grant_port  = PORT_D;
    // A pending fetch wins once data has used up its streak allowance.
    if (!d_req || (i_req && data_streak == 4'(MAX_DATA_STREAK)))
      grant_port = PORT_I;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one Avalon-MM master between fetch and data ports
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_hold,
  core_mem_arbiter_if.slave bus,
  output logic              grant_data
);

  arb_state_t state;
  arb_port_t  port;
  logic       is_write;
  logic [2:0] lat_cnt;
  logic [3:0] data_streak;

  logic       i_req;
  logic       d_req;
  logic       grant_valid;
  arb_port_t  grant_port;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  core_mem_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .i_req      (i_req),
    .d_req      (d_req),
    .data_streak(data_streak),
    .arb_hold   (arb_hold),
    .grant_valid(grant_valid),
    .grant_port (grant_port)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      port              <= PORT_I;
      is_write          <= 1'b0;
      lat_cnt           <= 3'd0;
      data_streak       <= 4'd0;
      grant_data        <= 1'b0;
      bus.m_read        <= 1'b0;
      bus.m_write       <= 1'b0;
      bus.m_addr        <= 32'd0;
      bus.m_writedata   <= 32'd0;
      bus.m_byteenable  <= 4'd0;
      bus.i_waitrequest <= 1'b1;
      bus.d_waitrequest <= 1'b1;
      bus.i_readdata    <= 32'd0;
      bus.d_readdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            port       <= grant_port;
            state      <= ISSUE;
            grant_data <= (grant_port == PORT_D);
            if (grant_port == PORT_D) begin
              is_write         <= bus.d_write;
              bus.m_read       <= !bus.d_write;
              bus.m_write      <= bus.d_write;
              bus.m_addr       <= bus.d_addr;
              bus.m_writedata  <= bus.d_writedata;
              bus.m_byteenable <= bus.d_byteenable;
              // The streak only counts data grants that made a fetch wait.
              if (!i_req)
                data_streak <= 4'd0;
              else if (data_streak != 4'(MAX_DATA_STREAK))
                data_streak <= data_streak + 4'd1;
            end else begin
              is_write         <= 1'b0;
              bus.m_read       <= 1'b1;
              bus.m_write      <= 1'b0;
              bus.m_addr       <= bus.i_addr;
              bus.m_byteenable <= FETCH_BYTEENABLE;
              data_streak      <= 4'd0;
            end
          end
        end
        ISSUE: begin
          if (!bus.m_waitrequest) begin
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            lat_cnt     <= 3'd1;
            if (is_write) begin
              state <= RESP;
              if (port == PORT_D) bus.d_waitrequest <= 1'b0;
              else                bus.i_waitrequest <= 1'b0;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (lat_cnt == 3'(READ_LATENCY)) begin
            state <= RESP;
            if (port == PORT_D) begin
              bus.d_readdata    <= bus.m_readdata;
              bus.d_waitrequest <= 1'b0;
            end else begin
              bus.i_readdata    <= bus.m_readdata;
              bus.i_waitrequest <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          bus.i_waitrequest <= 1'b1;
          bus.d_waitrequest <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;
  import core_mem_arb_pkg::*;

  localparam int RL  = 1;
  localparam int MDS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arb_hold = 1'b0;
  logic grant_data;

  core_mem_arbiter_if bus ();

  core_mem_arbiter #(
    .READ_LATENCY   (RL),
    .MAX_DATA_STREAK(MDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arb_hold  (arb_hold),
    .bus       (bus),
    .grant_data(grant_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int streak_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: data wins unless a fetch waits and data used its allowance.
  function automatic bit model_pick(input bit ir, input bit dr);
    bit d_wins;
    d_wins = dr && !(ir && streak_m >= MDS);
    if (d_wins && ir) streak_m = (streak_m + 1 > MDS) ? MDS : streak_m + 1;
    else              streak_m = 0;
    return d_wins;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_m_rw"}, {30'd0, bus.m_read, bus.m_write}, 32'd0);
    chk({tag, "_m_addr"}, bus.m_addr, 32'd0);
    chk({tag, "_m_wdata"}, bus.m_writedata, 32'd0);
    chk({tag, "_m_be"}, {28'd0, bus.m_byteenable}, 32'd0);
    chk({tag, "_waitreq"}, {30'd0, bus.i_waitrequest, bus.d_waitrequest}, 32'd3);
    chk({tag, "_i_rdata"}, bus.i_readdata, 32'd0);
    chk({tag, "_d_rdata"}, bus.d_readdata, 32'd0);
    chk({tag, "_grant_data"}, {31'd0, grant_data}, 32'd0);
    chk({tag, "_state"}, {30'd0, dut.state}, {30'd0, IDLE});
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after RESP with requests dropped.
  task automatic do_txn(input bit ir, input bit dr, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [3:0] be, input int stalls, input logic [31:0] rdv,
                        output bit won_d);
    bit wr;
    bus.i_read = ir;  bus.i_addr = ia;
    bus.d_read = dr;  bus.d_write = dw;
    bus.d_addr = da;  bus.d_writedata = dwd;  bus.d_byteenable = be;
    bus.m_waitrequest = (stalls > 0);
    won_d = model_pick(ir, dr | dw);
    wr = won_d && dw;
    tick;
    chk("grant_data", {31'd0, grant_data}, {31'd0, won_d});
    chk("m_addr", bus.m_addr, won_d ? da : ia);
    chk("m_byteenable", {28'd0, bus.m_byteenable}, {28'd0, (won_d ? be : 4'hF)});
    if (wr) chk("m_writedata", bus.m_writedata, dwd);
    bus.i_addr = $urandom;  bus.d_addr = $urandom;
    bus.d_writedata = $urandom;  bus.d_byteenable = 4'($urandom);
    bus.i_read = 1'($urandom_range(0, 1));
    arb_hold = 1'($urandom_range(0, 1));
    for (int k = 0; k <= stalls; k++) begin
      chk("issue_rw", {30'd0, bus.m_read, bus.m_write}, {30'd0, !wr, wr});
      chk("issue_waitreq", {30'd0, bus.i_waitrequest, bus.d_waitrequest}, 32'd3);
      if (k == stalls) bus.m_waitrequest = 1'b0;
      tick;
    end
    if (!wr) begin
      for (int k = 0; k < RL; k++) begin
        chk("rdwait_rw", {30'd0, bus.m_read, bus.m_write}, 32'd0);
        chk("rdwait_waitreq", {30'd0, bus.i_waitrequest, bus.d_waitrequest}, 32'd3);
        bus.m_readdata = (k == RL - 1) ? rdv : ~rdv;
        tick;
      end
      bus.m_readdata = rdv ^ 32'h5A5A_A5A5;
    end
    chk("resp_waitreq", {30'd0, bus.i_waitrequest, bus.d_waitrequest}, {30'd0, won_d, !won_d});
    chk("resp_rw", {30'd0, bus.m_read, bus.m_write}, 32'd0);
    if (!wr) chk(won_d ? "d_readdata" : "i_readdata", won_d ? bus.d_readdata : bus.i_readdata, rdv);
    bus.i_read = 1'b0;  bus.d_read = 1'b0;  bus.d_write = 1'b0;
    arb_hold = 1'b0;
    tick;
    chk("after_waitreq", {30'd0, bus.i_waitrequest, bus.d_waitrequest}, 32'd3);
  endtask

  initial begin
    bit wd;
    bit ir, dr, dw;
    logic [9:0] seq;
    bus.i_read = 0;  bus.i_addr = 0;
    bus.d_read = 0;  bus.d_write = 0;  bus.d_addr = 0;  bus.d_writedata = 0;  bus.d_byteenable = 0;
    bus.m_readdata = 0;  bus.m_waitrequest = 0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    reset = 1'b0;
    tick;

    do_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 32'hDEADBEEF, wd);
    chk("fetch_port", {31'd0, wd}, 32'd0);

    do_txn(0, 0, 1, 32'h0, 32'h2000, 32'h12345678, 4'b0011, 3, 32'h0, wd);
    chk("write_port", {31'd0, wd}, 32'd1);

    do_txn(0, 1, 1, 32'h0, 32'h3000, 32'hCAFEF00D, 4'b1100, 0, 32'h0, wd);

    seq = 10'd0;
    for (int n = 0; n < 10; n++) begin
      do_txn(1, 1, 0, 32'h4000 + n, 32'h5000 + n, 32'h0, 4'($urandom),
             int'($urandom_range(0, 2)), $urandom, wd);
      seq = {seq[8:0], wd};
    end
    chk("fairness_order", {22'd0, seq}, {22'd0, 10'b1111011110});

    arb_hold = 1'b1;
    bus.i_read = 1'b1;  bus.d_read = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick;
      chk("hold_no_cmd", {30'd0, bus.m_read, bus.m_write}, 32'd0);
    end
    arb_hold = 1'b0;
    do_txn(1, 1, 0, 32'h600, 32'h700, 32'h0, 4'hF, 0, 32'h01234567, wd);
    chk("hold_release_data", {31'd0, wd}, 32'd1);

    bus.i_read = 1'b1;  bus.i_addr = 32'h300;
    tick;
    tick;
    chk("mid_state", {30'd0, dut.state}, {30'd0, RDWAIT});
    reset = 1'b1;
    #1;
    check_reset("mid");
    bus.i_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    streak_m = 0;
    tick;
    do_txn(1, 0, 0, 32'h304, 32'h0, 32'h0, 4'h0, 1, 32'h0BADC0DE, wd);

    for (int n = 0; n < 40; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!ir && !dr && !dw) ir = 1'b1;
      do_txn(ir, dr, dw, $urandom, $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), $urandom, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares a single Avalon-MM memory master between the pipeline's instruction-fetch port (read-only) and data port (read/write). It allows one outstanding transaction at a time. Data requests have priority over instruction fetches, and a streak limit guarantees fetch progress. The block sits between the core's two memory master port groups and the system interconnect, and it provides a hold input so the debug halt logic can freeze new grants.

## Interface
Parameters:
- READ_LATENCY, 1, fixed downstream read latency in cycles after command acceptance (legal 1..7)
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending (legal 1..15)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- arb_hold  in  1  when high, no new grant is issued; an in-flight transaction still completes
- i_read  in  1  fetch request
- i_addr  in  32  fetch address
- i_readdata  out  32  fetch data; valid while i_waitrequest is low
- i_waitrequest  out  1  low for exactly one cycle, on fetch completion
- d_read, d_write  in  1 each  data request; if both are high, the request is treated as a write
- d_addr, d_writedata  in  32 each  data address and write data
- d_byteenable  in  4  data byte enables
- d_readdata  out  32  data read result
- d_waitrequest  out  1  low for exactly one cycle, on data completion
- m_addr, m_writedata  out  32 each  downstream command
- m_read, m_write  out  1 each  downstream command strobes
- m_byteenable  out  4  driven as 4'b1111 for fetches, d_byteenable for data
- m_readdata  in  32  downstream read data
- m_waitrequest  in  1  downstream command stall
- grant_data  out  1  high while the current or last grant belongs to the data port (debug)

## Operation
- FSM states:
  - IDLE: pick a winner, register the command, go to ISSUE.
  - ISSUE: drive m_* until m_waitrequest=0. Reads go to RDWAIT; writes go to RESP.
  - RDWAIT: count READ_LATENCY cycles from acceptance, capture m_readdata on the final count, go to RESP.
  - RESP: drop the winner's waitrequest for one cycle, drive captured data on the winner's readdata, go to IDLE.
- Grant rule in IDLE (arb_hold=0):
  - Only one port requesting: grant that port.
  - Both ports requesting: grant data unless data_streak == MAX_DATA_STREAK; in that case grant instruction.
- data_streak:
  - Incremented on every data grant while a fetch is pending, saturating at MAX_DATA_STREAK.
  - Cleared on every instruction grant, and on any data grant while no fetch is pending.
- Command capture: the address, write data and byte enables are registered at the grant edge. Later changes on the requester inputs are ignored until RESP.
- Protocol violation (requester drops its request mid-transaction): the transaction still completes downstream. The RESP cycle is still produced and read data is discarded by the requester.
- Waitrequest behaviour:
  - i_waitrequest and d_waitrequest stay high in every state except RESP for the granted port.
  - An idle port therefore sees waitrequest high.
- m_read and m_write are high only in ISSUE. m_* address and data hold their last value otherwise.

## Timing
- Reset values:
  - state IDLE, data_streak 0.
  - m_read, m_write: 0. m_addr, m_writedata, m_byteenable: 0.
  - i_waitrequest, d_waitrequest: 1.
  - i_readdata, d_readdata: 0. grant_data: 0.
- Reset is applied asynchronously at any state. Any transaction in flight is abandoned, with no RESP.
- Write latency: request seen at cycle 0 gives ISSUE in cycle 1. With no stall, RESP (waitrequest low) is in cycle 2.
- Read latency: request at cycle 0, accepted in cycle 1. m_readdata is sampled in cycle 1+READ_LATENCY, and RESP follows in cycle 2+READ_LATENCY. With the default latency, RESP is in cycle 3.
- Each cycle of m_waitrequest=1 in ISSUE adds one cycle of latency.
- Back-to-back: the cycle after RESP is IDLE, so a new grant issues at the earliest one cycle after RESP. A port that re-requests in its RESP cycle is therefore granted in the following IDLE cycle.
- arb_hold is sampled only in IDLE. Asserting it during ISSUE, RDWAIT or RESP has no effect on the current transaction.

## Structure
- Package core_mem_arb_pkg:
  - arb_state_t enum: IDLE, ISSUE, RDWAIT, RESP.
  - arb_port_t enum: PORT_I, PORT_D.
  - Constant FETCH_BYTEENABLE = 4'b1111.
- Sub-module core_mem_arb_select: a combinational grant decision. Inputs are i_req, d_req, data_streak, MAX_DATA_STREAK and arb_hold. Outputs are grant_valid and grant_port.
- The top level holds the FSM, the command and data registers, the latency counter (3 bits) and the streak counter (4 bits).

## Test plan
- Single fetch: i_read with i_addr=0x100, m_readdata=0xDEADBEEF with no stall. Required: m_read high in cycle 1; i_waitrequest low only in cycle 3, with i_readdata=0xDEADBEEF.
- Data write with stall: d_write to 0x2000 with data 0x12345678, byteenable 4'b0011, and m_waitrequest high for 3 cycles. Required: m_write held for 4 cycles; d_waitrequest low in cycle 5; m_byteenable=4'b0011.
- Fairness: both ports request continuously with MAX_DATA_STREAK=4. Required grant order is D, D, D, D, I, D, D, D, D, I.
- Hold: arb_hold=1 with both ports requesting for 10 cycles. Required: no m_read or m_write during that time. After release, the data port is granted first.
- Reset mid-read: assert reset during RDWAIT. Required: all outputs take their reset values immediately and the FSM is IDLE. After release, a new fetch completes normally.
- Read+write collision: d_read and d_write both high. Required: m_write=1 and m_read=0.
